// File: rtl/exp_freq_integ_pkg.sv
// Shared definitions for the e^x engine: Q-format widths, engine state
// encodings and the 1/i! coefficient table (Q0.16).
package exp_pkg;

    localparam int FRAC_W = 16;   // Q0.16 operand / fraction width
    localparam int SUM_W  = 18;   // Q2.16 running sum width
    localparam int PROD_W = 32;   // full 16x16 product width

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_MULX  = 3'd2;
    localparam logic [2:0] ST_MULC  = 3'd3;
    localparam logic [2:0] ST_ACCUM = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    // 1/i! in Q0.16 for i = 2..7; i = 0,1 are never looked up.
    function automatic logic [FRAC_W-1:0] invfact(input logic [2:0] i);
        case (i)
            3'd2:    invfact = 16'h8000;
            3'd3:    invfact = 16'h2AAB;
            3'd4:    invfact = 16'h0AAB;
            3'd5:    invfact = 16'h0222;
            3'd6:    invfact = 16'h005B;
            3'd7:    invfact = 16'h000D;
            default: invfact = 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/exp_freq_integ_if.sv
// Bundle of the e^x engine's measurement, request and result signals.
// master = stimulus side, slave = engine side.
interface exp_freq_integ_if;

    logic        f;
    logic        adjust;
    logic [2:0]  n;
    logic        start;
    logic [15:0] x;
    logic        valid;
    logic [7:0]  k;
    logic        acc_out;
    logic        done;
    logic [1:0]  intpart;
    logic [15:0] fracpart;
    logic [2:0]  curState;

    modport master (
        output f, adjust, n, start, x,
        input  valid, k, acc_out, done, intpart, fracpart, curState
    );

    modport slave (
        input  f, adjust, n, start, x,
        output valid, k, acc_out, done, intpart, fracpart, curState
    );

endinterface

// File: rtl/exp_freq_integ_freq_meter.sv
// Frequency meter plus phase accumulator: counts rising edges of f over a
// 2**WIN_LOG2 clk window after adjust falls, publishes k/valid, and turns k
// into a clock-enable pulse train acc_out at rate k/2**(8+n) per clk.
module freq_meter #(
    parameter int WIN_LOG2 = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       f,
    input  logic       adjust,
    input  logic [2:0] n,
    output logic       valid,
    output logic [7:0] k,
    output logic       acc_out
);

    logic [2:0]          f_sync;      // [1:0] synchroniser, [2] edge history
    logic                rise;
    logic                adj_d;
    logic                measuring;
    logic [WIN_LOG2-1:0] win_cnt;
    logic [7:0]          edge_cnt;
    logic [7:0]          edge_next;
    logic [15:0]         acc;
    logic [15:0]         acc_sum;
    logic [3:0]          tap;

    assign rise      = f_sync[1] & ~f_sync[2];
    assign edge_next = (rise && edge_cnt != 8'hFF) ? edge_cnt + 8'd1 : edge_cnt;
    assign acc_sum   = acc + {8'h00, k};
    assign tap       = 4'd8 + {1'b0, n};

    // Bring f into the clk domain and keep one stage of history for edge detect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) f_sync <= '0;
        else     f_sync <= {f_sync[1:0], f};
    end

    // Measurement window: held clear during adjust, started on its falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adj_d     <= 1'b0;
            measuring <= 1'b0;
            win_cnt   <= '0;
            edge_cnt  <= '0;
            k         <= '0;
            valid     <= 1'b0;
        end else begin
            adj_d <= adjust;
            if (adjust) begin
                measuring <= 1'b0;
                win_cnt   <= '0;
                edge_cnt  <= '0;
                valid     <= 1'b0;
            end else if (adj_d) begin
                measuring <= 1'b1;
                win_cnt   <= '0;
                edge_cnt  <= '0;
            end else if (measuring) begin
                edge_cnt <= edge_next;
                win_cnt  <= win_cnt + 1'b1;
                if (&win_cnt) begin
                    k         <= edge_next;
                    valid     <= 1'b1;
                    measuring <= 1'b0;
                end
            end
        end
    end

    // Phase accumulator; k never reaches bit 8+n, so the carry into that bit
    // is just the flip of the sum bit relative to the old accumulator bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            acc_out <= 1'b0;
        end else if (!valid) begin
            acc     <= '0;
            acc_out <= 1'b0;
        end else begin
            acc     <= acc_sum;
            acc_out <= acc_sum[tap] ^ acc[tap];
        end
    end

endmodule

// File: rtl/exp_freq_integ.sv
// Top of the Exp4 datapath: fixed-point e^x Taylor engine paced by the
// calibrated enable from freq_meter, using one shared 16x16 multiplier.
// Optional macro ROUND_EN: products round to nearest instead of truncating.
module exp_freq_integ
    import exp_pkg::*;
#(
    parameter int WIN_LOG2 = 8,
    parameter int NTERMS   = 8
) (
    input  logic clk,
    input  logic rst,
    exp_freq_integ_if.slave bus
);

    logic              valid;
    logic [7:0]        k;
    logic              acc_out;
    logic [2:0]        state;
    logic [FRAC_W-1:0] x_reg;
    logic [FRAC_W-1:0] p;
    logic [FRAC_W-1:0] t;
    logic [SUM_W-1:0]  sum;
    logic [2:0]        idx;
    logic              done;
    logic [1:0]        intpart;
    logic [FRAC_W-1:0] fracpart;
    logic [FRAC_W-1:0] mul_b;
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] prod_adj;
    logic [FRAC_W-1:0] prod_q;

    freq_meter #(.WIN_LOG2(WIN_LOG2)) u_meter (
        .clk     (clk),
        .rst     (rst),
        .f       (bus.f),
        .adjust  (bus.adjust),
        .n       (bus.n),
        .valid   (valid),
        .k       (k),
        .acc_out (acc_out)
    );

    // Shared multiplier: p times x in MULX, p times 1/i! in MULC.
    assign mul_b = (state == ST_MULX) ? x_reg : invfact(idx);
    assign prod  = {16'h0000, p} * {16'h0000, mul_b};
`ifdef ROUND_EN
    assign prod_adj = prod + 32'h0000_8000;
`else
    assign prod_adj = prod;
`endif
    assign prod_q = 16'(prod_adj >> FRAC_W);

    // Engine FSM: advances only on enable pulses, so it freezes while valid=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            x_reg    <= '0;
            p        <= '0;
            t        <= '0;
            sum      <= '0;
            idx      <= '0;
            done     <= 1'b0;
            intpart  <= '0;
            fracpart <= '0;
        end else if (acc_out) begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    x_reg <= bus.x;
                    p     <= bus.x;
                    sum   <= 18'h10000 + {2'b00, bus.x};
                    idx   <= 3'd2;
                    done  <= 1'b0;
                    state <= ST_MULX;
                end
                ST_MULX: begin
                    p     <= prod_q;
                    state <= ST_MULC;
                end
                ST_MULC: begin
                    t     <= prod_q;
                    state <= ST_ACCUM;
                end
                ST_ACCUM: begin
                    sum <= sum + {2'b00, t};
                    if (idx == 3'(NTERMS - 1)) begin
                        state <= ST_DONE;
                    end else begin
                        idx   <= idx + 3'd1;
                        state <= ST_MULX;
                    end
                end
                ST_DONE: begin
                    {intpart, fracpart} <= sum;
                    done                <= 1'b1;
                    if (!bus.start) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.valid    = valid;
    assign bus.k        = k;
    assign bus.acc_out  = acc_out;
    assign bus.done     = done;
    assign bus.intpart  = intpart;
    assign bus.fracpart = fracpart;
    assign bus.curState = state;

endmodule

// File: tb/tb_exp_freq_integ.sv
// Directed bench for exp_freq_integ: reset, calibration, enable rate,
// e^x results for three operands, and asynchronous reset mid-compute.
module tb_exp_freq_integ;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic f_gen = 1'b0;
    int   errors = 0;
    int   checks = 0;

    exp_freq_integ_if bus();

    exp_freq_integ #(.WIN_LOG2(8), .NTERMS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;       // 100 MHz
    always #50 f_gen = ~f_gen;  // 10 MHz
    assign bus.f = f_gen;

    task automatic test_reset();
        rst = 1'b1;
        bus.adjust = 1'b0;
        bus.n = 3'd0;
        bus.start = 1'b0;
        bus.x = 16'h0000;
        repeat (3) @(negedge clk);
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0h expected 0", bus.valid); end
        checks++; if (bus.k !== 8'd0) begin errors++; $display("FAIL reset_k: got %0d expected 0", bus.k); end
        checks++; if (bus.acc_out !== 1'b0) begin errors++; $display("FAIL reset_acc_out: got %0h expected 0", bus.acc_out); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0h expected 0", bus.done); end
        checks++; if (bus.intpart !== 2'd0) begin errors++; $display("FAIL reset_intpart: got %0h expected 0", bus.intpart); end
        checks++; if (bus.fracpart !== 16'h0000) begin errors++; $display("FAIL reset_fracpart: got %0h expected 0", bus.fracpart); end
        checks++; if (bus.curState !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", bus.curState); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_calibrate();
        int cyc;
        bus.adjust = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL cal_valid_low: got %0h expected 0", bus.valid); end
        bus.adjust = 1'b0;
        cyc = 0;
        while (bus.valid !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL cal_valid_timeout: got %0h expected 1", bus.valid); end
        checks++; if (cyc < 256 || cyc > 260) begin errors++; $display("FAIL cal_window: got %0d cycles expected 256..260", cyc); end
        checks++; if (bus.k !== 8'd25 && bus.k !== 8'd26) begin errors++; $display("FAIL cal_k: got %0d expected 25 or 26", bus.k); end
    endtask

    task automatic test_rate();
        int c0, c2;
        c0 = 0; c2 = 0;
        bus.n = 3'd0;
        @(negedge clk);
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            if (bus.acc_out === 1'b1) c0++;
        end
        bus.n = 3'd2;
        @(negedge clk);
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            if (bus.acc_out === 1'b1) c2++;
        end
        checks++; if (c0 < 99 || c0 > 105) begin errors++; $display("FAIL rate_n0: got %0d pulses expected 99..105", c0); end
        checks++; if (c2 < 24 || c2 > 27) begin errors++; $display("FAIL rate_n2: got %0d pulses expected 24..27", c2); end
        checks++; if (c0 - 4 * c2 > 8 || 4 * c2 - c0 > 8) begin errors++; $display("FAIL rate_ratio: got %0d vs 4*%0d expected ratio 4:1", c0, c2); end
        bus.n = 3'd0;
        @(negedge clk);
    endtask

    task automatic test_compute(input logic [15:0] xin, input logic [15:0] exp_frac,
                                input int tol, input string name);
        logic [2:0]  prev, cur;
        logic [14:0] walk;
        logic [15:0] held;
        int nwalk, loops, illegal, diff, c;
        logic seen_mulx, done_mulx, finished;
        bus.x = xin;
        bus.start = 1'b1;
        prev = bus.curState;
        walk = {12'b0, prev};
        nwalk = 1; loops = 0; illegal = 0;
        seen_mulx = 1'b0; done_mulx = 1'bx; finished = 1'b0;
        for (c = 0; c < 4000 && !finished; c++) begin
            @(negedge clk);
            cur = bus.curState;
            if (cur != prev) begin
                if (nwalk < 5) begin walk = {walk[11:0], cur}; nwalk++; end
                case (prev)
                    3'd0: if (cur != 3'd1) illegal++;
                    3'd1: if (cur != 3'd2) illegal++;
                    3'd2: if (cur != 3'd3) illegal++;
                    3'd3: if (cur != 3'd4) illegal++;
                    3'd4: if (cur == 3'd2) loops++; else if (cur != 3'd5) illegal++;
                    default: illegal++;
                endcase
                if (cur == 3'd2 && !seen_mulx) begin seen_mulx = 1'b1; done_mulx = bus.done; end
                prev = cur;
            end
            if (seen_mulx && bus.done === 1'b1 && cur == 3'd5) finished = 1'b1;
        end
        checks++; if (!finished) begin errors++; $display("FAIL %s_timeout: got state %0d expected DONE with done=1", name, bus.curState); end
        checks++; if (walk !== 15'o01234) begin errors++; $display("FAIL %s_walk: got %o expected 01234", name, walk); end
        checks++; if (illegal != 0) begin errors++; $display("FAIL %s_transitions: got %0d illegal expected 0", name, illegal); end
        checks++; if (loops != 5) begin errors++; $display("FAIL %s_loops: got %0d expected 5", name, loops); end
        checks++; if (done_mulx !== 1'b0) begin errors++; $display("FAIL %s_done_drop: got %0h expected 0", name, done_mulx); end
        checks++; if (bus.intpart !== 2'd1) begin errors++; $display("FAIL %s_intpart: got %0d expected 1", name, bus.intpart); end
        diff = int'(bus.fracpart) - int'(exp_frac);
        if (diff < 0) diff = -diff;
        checks++; if (diff > tol) begin errors++; $display("FAIL %s_fracpart: got %0h expected %0h +/-%0d", name, bus.fracpart, exp_frac, tol); end
        held = bus.fracpart;
        repeat (30) @(negedge clk);
        checks++; if (bus.curState !== 3'd5) begin errors++; $display("FAIL %s_hold_done: got state %0d expected 5", name, bus.curState); end
        bus.start = 1'b0;
        for (c = 0; c < 200 && bus.curState !== 3'd0; c++) @(negedge clk);
        checks++; if (bus.curState !== 3'd0) begin errors++; $display("FAIL %s_to_idle: got state %0d expected 0", name, bus.curState); end
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL %s_done_held: got %0h expected 1", name, bus.done); end
        checks++; if (bus.fracpart !== held) begin errors++; $display("FAIL %s_frac_held: got %0h expected %0h", name, bus.fracpart, held); end
    endtask

    task automatic test_reset_mid();
        int c;
        bus.x = 16'h8000;
        bus.start = 1'b1;
        for (c = 0; c < 1000 && bus.curState !== 3'd3; c++) @(negedge clk);
        checks++; if (bus.curState !== 3'd3) begin errors++; $display("FAIL mid_reach_mulc: got state %0d expected 3", bus.curState); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.curState !== 3'd0) begin errors++; $display("FAIL mid_state: got %0d expected 0", bus.curState); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mid_done: got %0h expected 0", bus.done); end
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %0h expected 0", bus.valid); end
        checks++; if (bus.k !== 8'd0) begin errors++; $display("FAIL mid_k: got %0d expected 0", bus.k); end
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_calibrate();
        test_rate();
        test_compute(16'h8000, 16'hA612, 8, "x8000");
        test_compute(16'h0000, 16'h0000, 0, "x0000");
        test_compute(16'h4000, 16'h48B6, 8, "x4000");
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
